// File: rtl/config_write_scheduler_pkg.sv
// Shared types for the config-bus write scheduler: the write record, the
// register-class bit and the issue FSM states.
package config_write_scheduler_pkg;

  // Register-number bit that selects voice-operator (1) versus global (0) registers.
  localparam int unsigned CFG_CLASS_BIT = 14;
  localparam int unsigned CFG_NUMBER_W  = 15;
  localparam int unsigned CFG_VALUE_W   = 16;

  typedef struct packed {
    logic [CFG_NUMBER_W-1:0] Number;
    logic [CFG_VALUE_W-1:0]  Value;
  } ConfigWrite_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    DRAIN
  } ConfigSchedState_t;

  // Voice-operator writes may issue at any time; globals are frame-aligned.
  function automatic logic is_voice_op(input ConfigWrite_t w);
    return w.Number[CFG_CLASS_BIT];
  endfunction

endpackage

// File: rtl/config_write_scheduler_fifo.sv
// Small synchronous FIFO of config writes with registered pointers and count.
// Depth is a power of two, so the pointers wrap naturally at FIFO_DEPTH.
module config_write_fifo
  import config_write_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic         push,
  input  ConfigWrite_t push_data,
  input  logic         pop,
  output ConfigWrite_t head,
  output logic [CntW-1:0] count,
  output logic         full,
  output logic         empty
);

  ConfigWrite_t      mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q;
  logic [AddrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push;
  logic              do_pop;

  // Overflow/underflow requests are dropped rather than corrupting state.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy registers.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/config_write_scheduler.sv
// Config-bus write scheduler: round-robin arbitration between requesters, an
// in-order write queue, and an issue FSM that holds global writes until the
// next sample-frame boundary so note-on changes land atomically per frame.
module config_write_scheduler
  import config_write_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_ReqValid,
  output logic [NUM_REQ-1:0]     o_ReqReady,
  input  logic [NUM_REQ*15-1:0]  i_ReqNumber,
  input  logic [NUM_REQ*16-1:0]  i_ReqValue,
  input  logic                   i_FrameStart,
  output logic                   o_WriteEnable,
  output logic [14:0]            o_WriteNumber,
  output logic [15:0]            o_WriteValue,
  output logic                   o_Busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   grant_idx;
  logic [PtrW-1:0]   scan_idx;
  logic [NUM_REQ-1:0] grant;

  logic              push;
  ConfigWrite_t      push_data;
  logic              pop;
  ConfigWrite_t      head;
  logic [CntW-1:0]   count;
  logic              full;
  logic              empty;

  ConfigSchedState_t state_q, state_d;

  logic              we_q;
  logic [14:0]       num_q;
  logic [15:0]       val_q;

  // Round-robin pick: first valid requester at or after the pointer. Ready
  // looks only at the registered full flag, never at a same-cycle pop.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    rr_ptr_d  = rr_ptr_q;
    if (i_Reset && !full) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        scan_idx = PtrW'((32'(rr_ptr_q) + i) % NUM_REQ);
        if (grant == '0 && i_ReqValid[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          grant_idx       = scan_idx;
        end
      end
      if (grant != '0) rr_ptr_d = PtrW'((32'(grant_idx) + 1) % NUM_REQ);
    end
  end

  assign o_ReqReady       = grant;
  assign push             = |grant;
  assign push_data.Number = i_ReqNumber[32'(grant_idx)*15 +: 15];
  assign push_data.Value  = i_ReqValue[32'(grant_idx)*16 +: 16];

  config_write_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Issue FSM: voice-op heads go straight out; a global head parks the queue
  // (including any voice-ops behind it) until a frame pulse, then the run of
  // globals drains back-to-back.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (is_voice_op(head)) begin
            pop = 1'b1;
          end else if (i_FrameStart) begin
            // A global arriving at the head on the pulse cycle still catches it.
            pop     = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = WAIT_FRAME;
          end
        end
      end
      WAIT_FRAME: begin
        if (i_FrameStart && !empty) begin
          pop     = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = IDLE;
        end else begin
          pop = 1'b1;
          if (is_voice_op(head)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and arbitration pointer.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Registered bus outputs; number/value hold between strobes.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      we_q  <= 1'b0;
      num_q <= '0;
      val_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        num_q <= head.Number;
        val_q <= head.Value;
      end
    end
  end

  assign o_WriteEnable = we_q;
  assign o_WriteNumber = num_q;
  assign o_WriteValue  = val_q;
  assign o_Busy        = (count != '0) | we_q;

endmodule

// File: tb/tb_config_write_scheduler.sv
// Self-checking bench for config_write_scheduler: table of single voice-op
// writes plus hand-built sequences for frame gating, draining, fairness,
// full-queue back-pressure and reset during a drain.
module tb_config_write_scheduler;
  import config_write_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic [1:0]  i_ReqValid = '0;
  logic [1:0]  o_ReqReady;
  logic [29:0] i_ReqNumber = '0;
  logic [31:0] i_ReqValue = '0;
  logic        i_FrameStart = 1'b0;
  logic        o_WriteEnable;
  logic [14:0] o_WriteNumber;
  logic [15:0] o_WriteValue;
  logic        o_Busy;

  config_write_scheduler #(
    .NUM_REQ    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (i_Reset),
    .i_ReqValid    (i_ReqValid),
    .o_ReqReady    (o_ReqReady),
    .i_ReqNumber   (i_ReqNumber),
    .i_ReqValue    (i_ReqValue),
    .i_FrameStart  (i_FrameStart),
    .o_WriteEnable (o_WriteEnable),
    .o_WriteNumber (o_WriteNumber),
    .o_WriteValue  (o_WriteValue),
    .o_Busy        (o_Busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_cyc = -1;
  int acc_cyc = 0;
  int last_strobe = 0;
  int strobe_cnt = 0;
  int base;

  ConfigWrite_t exp_q[$];
  ConfigWrite_t req_q0[$];
  ConfigWrite_t req_q1[$];
  int           grant_log[$];
  int           strobe_log[$];

  typedef struct {
    int          req;
    logic [14:0] num;
    logic [15:0] val;
    int          lat;
  } vec_t;
  vec_t vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Frame pulse driver: high for exactly the cycle numbered frame_cyc.
  initial forever begin
    @(posedge clk);
    #1;
    i_FrameStart = (cyc == frame_cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest accepted write.
  initial forever begin
    @(negedge clk);
    if (i_Reset === 1'b1 && o_WriteEnable === 1'b1) begin
      strobe_cnt++;
      last_strobe = cyc;
      strobe_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        ConfigWrite_t e;
        e = exp_q.pop_front();
        check("strobe_number", 32'(o_WriteNumber), 32'(e.Number));
        check("strobe_value", 32'(o_WriteValue), 32'(e.Value));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_req(input int r, input logic [14:0] n, input logic [15:0] v);
    ConfigWrite_t w;
    w.Number = n;
    w.Value  = v;
    if (r == 0) req_q0.push_back(w);
    else req_q1.push_back(w);
  endtask

  // Present queued words on both requesters; the scoreboard entry is pushed
  // at the handshake. Called and returns at #1 after a rising edge.
  task automatic drive_reqs(input int budget, input bit must_finish);
    logic [1:0] g;
    int n;
    n = 0;
    while ((req_q0.size() != 0 || req_q1.size() != 0) && n < budget) begin
      i_ReqValid = {req_q1.size() != 0, req_q0.size() != 0};
      if (req_q0.size() != 0) begin
        i_ReqNumber[14:0] = req_q0[0].Number;
        i_ReqValue[15:0]  = req_q0[0].Value;
      end
      if (req_q1.size() != 0) begin
        i_ReqNumber[29:15] = req_q1[0].Number;
        i_ReqValue[31:16]  = req_q1[0].Value;
      end
      @(negedge clk);
      g = i_ReqValid & o_ReqReady;
      if (g != 2'b00) begin
        check("grant_onehot", 32'($onehot(g)), 32'd1);
        if (g[0]) begin
          exp_q.push_back(req_q0[0]);
          grant_log.push_back(0);
        end else begin
          exp_q.push_back(req_q1[0]);
          grant_log.push_back(1);
        end
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (g[0]) void'(req_q0.pop_front());
      else if (g[1]) void'(req_q1.pop_front());
      n++;
    end
    i_ReqValid = '0;
    if (must_finish) check("drive_done", 32'(req_q0.size() + req_q1.size()), 32'd0);
  endtask

  task automatic apply_reset();
    i_Reset = 1'b0;
    i_ReqValid = '0;
    tick(2);
    exp_q.delete();
    req_q0.delete();
    req_q1.delete();
    grant_log.delete();
    strobe_log.delete();
    strobe_cnt = 0;
    frame_cyc = -1;
    i_Reset = 1'b1;
    tick(1);
  endtask

  initial begin
    vecs[0] = '{req: 0, num: 15'h4105, val: 16'h00A5, lat: 2};
    vecs[1] = '{req: 1, num: 15'h4ABC, val: 16'h1234, lat: 2};
    vecs[2] = '{req: 0, num: 15'h7FFF, val: 16'hFFFF, lat: 2};
    vecs[3] = '{req: 1, num: 15'h4000, val: 16'h0000, lat: 2};

    @(posedge clk);
    #1;

    // Reset state, with requests pending so ready gating is visible.
    i_Reset     = 1'b0;
    i_ReqValid  = 2'b11;
    i_ReqNumber = {15'h4001, 15'h4002};
    i_ReqValue  = 32'hDEAD_BEEF;
    tick(2);
    @(negedge clk);
    check("rst_ready", 32'(o_ReqReady), 32'd0);
    check("rst_we", 32'(o_WriteEnable), 32'd0);
    check("rst_number", 32'(o_WriteNumber), 32'd0);
    check("rst_value", 32'(o_WriteValue), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);
    @(posedge clk);
    #1;
    apply_reset();

    // Voice-op writes: strobe exactly two cycles after the accept.
    for (int i = 0; i < 4; i++) begin
      base = strobe_cnt;
      push_req(vecs[i].req, vecs[i].num, vecs[i].val);
      drive_reqs(4, 1'b1);
      tick(4);
      check("voice_latency", 32'(last_strobe - acc_cyc), 32'(vecs[i].lat));
      check("voice_count", 32'(strobe_cnt - base), 32'd1);
    end

    // A frame pulse while idle is ignored; the global waits for the next one.
    frame_cyc = cyc + 2;
    tick(5);
    base = strobe_cnt;
    frame_cyc = cyc + 30;
    push_req(0, 15'h0000, 16'hFFFF);
    drive_reqs(4, 1'b1);
    while (cyc < frame_cyc) tick(1);
    @(negedge clk);
    check("global_held", 32'(strobe_cnt - base), 32'd0);
    check("global_busy", 32'(o_Busy), 32'd1);
    @(posedge clk);
    #1;
    tick(3);
    check("global_count", 32'(strobe_cnt - base), 32'd1);
    check("global_time", 32'(last_strobe - frame_cyc), 32'd1);

    // Global reaching the head on the very cycle of the pulse.
    base = strobe_cnt;
    frame_cyc = cyc + 1;
    push_req(1, 15'h0042, 16'h0F0F);
    drive_reqs(4, 1'b1);
    tick(4);
    check("same_cycle_frame_count", 32'(strobe_cnt - base), 32'd1);
    check("same_cycle_frame_time", 32'(last_strobe - acc_cyc), 32'd2);

    // Drain ordering: two globals then a voice-op, strobes on consecutive cycles.
    strobe_log.delete();
    frame_cyc = cyc + 10;
    push_req(0, 15'h0000, 16'h1234);
    push_req(0, 15'h0100, 16'h5678);
    push_req(0, 15'h4000, 16'h0042);
    drive_reqs(8, 1'b1);
    while (cyc < frame_cyc + 5) tick(1);
    check("drain_count", 32'(strobe_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < strobe_log.size()) check("drain_time", 32'(strobe_log[i] - frame_cyc), 32'(i + 1));
    end
    push_req(1, 15'h4321, 16'hBEEF);
    drive_reqs(4, 1'b1);
    tick(4);
    check("post_drain_idle_latency", 32'(last_strobe - acc_cyc), 32'd2);

    // Fairness from reset: alternating grants, six strobes in grant order.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_req(0, 15'(15'h4100 + i), 16'(16'hA000 + i));
      push_req(1, 15'(15'h4200 + i), 16'(16'hB000 + i));
    end
    drive_reqs(20, 1'b1);
    check("rr_grants", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) check("rr_order", 32'(grant_log[i]), 32'(i % 2));
    end
    tick(4);
    check("rr_strobes", 32'(strobe_cnt), 32'd6);

    // Full queue behind a parked global.
    apply_reset();
    push_req(0, 15'h0000, 16'hAAAA);
    for (int i = 1; i <= 4; i++) push_req(0, 15'(15'h4000 + i), 16'(i));
    drive_reqs(6, 1'b0);
    check("full_left", 32'(req_q0.size()), 32'd1);
    i_ReqValid = 2'b01;
    i_ReqNumber[14:0] = req_q0[0].Number;
    i_ReqValue[15:0]  = req_q0[0].Value;
    @(negedge clk);
    check("full_ready", 32'(o_ReqReady), 32'd0);
    check("full_busy", 32'(o_Busy), 32'd1);
    check("full_no_strobe", 32'(strobe_cnt), 32'd0);
    @(posedge clk);
    #1;
    frame_cyc = cyc + 2;
    drive_reqs(10, 1'b1);
    check("full_fifth_accept", 32'(acc_cyc - frame_cyc), 32'd1);
    tick(8);
    check("full_strobes", 32'(strobe_cnt), 32'd5);
    check("full_last_time", 32'(last_strobe - frame_cyc), 32'd5);

    // Reset pulse during the second strobe of a drain.
    apply_reset();
    frame_cyc = cyc + 10;
    for (int i = 1; i <= 4; i++) push_req(0, 15'(i), 16'(16'h1111 * i));
    drive_reqs(8, 1'b1);
    while (cyc < frame_cyc + 2) tick(1);
    check("mid_drain_first", 32'(strobe_cnt), 32'd1);
    i_Reset = 1'b0;
    i_ReqValid = 2'b11;
    tick(1);
    @(negedge clk);
    check("mid_rst_we", 32'(o_WriteEnable), 32'd0);
    check("mid_rst_number", 32'(o_WriteNumber), 32'd0);
    check("mid_rst_value", 32'(o_WriteValue), 32'd0);
    check("mid_rst_busy", 32'(o_Busy), 32'd0);
    check("mid_rst_ready", 32'(o_ReqReady), 32'd0);
    @(posedge clk);
    #1;
    i_ReqValid = '0;
    i_Reset = 1'b1;
    exp_q.delete();
    base = strobe_cnt;
    frame_cyc = cyc + 3;
    tick(10);
    check("post_rst_no_strobe", 32'(strobe_cnt - base), 32'd0);
    @(negedge clk);
    check("post_rst_busy", 32'(o_Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
